// File: rtl/fpmm_pkg.sv
// Shared definitions for the FP32 multiplier arbiter: defaults, FSM encoding
// and the tag that travels alongside each product.
package fpmm_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int MUL_LAT_DEF = 1;
  localparam int IDX_W       = 3;   // wide enough for up to 8 requesters

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             last;
  } mul_tag_t;

endpackage

// File: rtl/multiplier_32bit.sv
// IEEE-754 single multiplier, round-to-nearest-even, subnormals flushed to zero,
// with a LAT-stage output pipeline; ovf flags Inf/NaN/overflow results.
module multiplier_32bit #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vld,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_vld,
  output logic [31:0] o_res,
  output logic        o_ovf
);

  logic        sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic        norm, grd, stk;
  logic [22:0] mant;
  logic [23:0] rnd;
  logic [9:0]  exp_r;
  logic [31:0] res_c;
  logic        ovf_c;

  logic        vld_q [LAT];
  logic [31:0] res_q [LAT];
  logic        ovf_q [LAT];

  always_comb begin
    sgn    = i_a[31] ^ i_b[31];
    a_zero = (i_a[30:23] == 8'h00);
    b_zero = (i_b[30:23] == 8'h00);
    a_inf  = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'h0);
    b_inf  = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'h0);
    a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'h0);
    b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'h0);

    prod  = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
    norm  = prod[47];
    mant  = norm ? prod[46:24] : prod[45:23];
    grd   = norm ? prod[23]    : prod[22];
    stk   = norm ? |prod[22:0] : |prod[21:0];
    rnd   = {1'b0, mant} + {23'h0, grd & (stk | mant[0])};
    // a rounding carry leaves rnd[22:0] all zero, so only the exponent moves
    exp_r = {2'b00, i_a[30:23]} + {2'b00, i_b[30:23]} + {9'h0, norm}
          + {9'h0, rnd[23]} - 10'd127;

    res_c = 32'h0;
    ovf_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res_c = 32'h7FC00000;
      ovf_c = 1'b1;
    end else if (a_inf || b_inf) begin
      res_c = {sgn, 31'h7F800000};
      ovf_c = 1'b1;
    end else if (a_zero || b_zero) begin
      res_c = {sgn, 31'h0};
    end else if (exp_r[9] || (exp_r == 10'd0)) begin
      res_c = {sgn, 31'h0};
    end else if (exp_r >= 10'd255) begin
      res_c = {sgn, 31'h7F800000};
      ovf_c = 1'b1;
    end else begin
      res_c = {sgn, exp_r[7:0], rnd[22:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        vld_q[k] <= 1'b0;
        res_q[k] <= 32'h0;
        ovf_q[k] <= 1'b0;
      end
    end else begin
      vld_q[0] <= i_vld;
      res_q[0] <= i_vld ? res_c : 32'h0;
      ovf_q[0] <= i_vld & ovf_c;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        res_q[k] <= res_q[k-1];
        ovf_q[k] <= ovf_q[k-1];
      end
    end
  end

  assign o_vld = vld_q[LAT-1];
  assign o_res = res_q[LAT-1];
  assign o_ovf = ovf_q[LAT-1];

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier among N_REQ requesters,
// holding the grant for a whole burst and tagging products back to their owner.
//   state  | meaning
//   IDLE   | no owner; round-robin pick from rr_ptr among valid requesters
//   LOCKED | owner fixed; only the owner is ready until it sends req_last
module fp_mul_arbiter
  import fpmm_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_rdy,
  output logic [N_REQ-1:0]   rsp_vld,
  output logic [31:0]        rsp_res,
  output logic               rsp_ovf,
  output logic               rsp_last,
  output logic               busy
);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt, rr_ptr, rr_nxt;
  logic [IDX_W-1:0] pick, sel;
  logic             found, grant, issue, sel_vld, sel_last, in_flight;
  logic [31:0]      op_a, op_b, mul_res;
  logic             mul_vld, mul_ovf;
  mul_tag_t         tag_pipe [MUL_LAT];
  mul_tag_t         tag_out;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (int'(v) >= N_REQ - 1) return '0;
    return v + 1'b1;
  endfunction

  // Round-robin: first valid at or above rr_ptr, otherwise first valid below it.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_vld[j] && (j >= int'(rr_ptr))) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_vld[j] && (j < int'(rr_ptr))) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    sel       = owner;
    grant     = 1'b0;
    case (state)
      IDLE:    begin sel = pick;  grant = found; end
      LOCKED:  begin sel = owner; grant = 1'b1;  end
      default: ;
    endcase

    sel_vld  = 1'b0;
    sel_last = 1'b0;
    op_a     = 32'h0;
    op_b     = 32'h0;
    for (int j = 0; j < N_REQ; j++) begin
      if (IDX_W'(j) == sel) begin
        sel_vld  = req_vld[j];
        sel_last = req_last[j];
        op_a     = req_a[32*j +: 32];
        op_b     = req_b[32*j +: 32];
      end
    end

    issue = grant & sel_vld & ~rst;
    if (issue) begin
      if (sel_last) begin
        state_nxt = IDLE;
        rr_nxt    = wrap_inc(sel);
      end else begin
        state_nxt = LOCKED;
        owner_nxt = sel;
      end
    end
  end

  assign req_rdy = (grant && !rst) ? (N_REQ'(1) << sel) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Tag shift register runs in lockstep with the multiplier pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= mul_tag_t'{vld: issue, idx: sel, last: sel_last};
      for (int k = 1; k < MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_comb begin
    in_flight = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) in_flight = in_flight | tag_pipe[k].vld;
  end

  multiplier_32bit #(.LAT(MUL_LAT)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .i_vld (issue),
    .i_a   (op_a),
    .i_b   (op_b),
    .o_vld (mul_vld),
    .o_res (mul_res),
    .o_ovf (mul_ovf)
  );

  assign tag_out  = tag_pipe[MUL_LAT-1];
  assign rsp_vld  = tag_out.vld ? (N_REQ'(1) << tag_out.idx) : '0;
  assign rsp_res  = mul_vld ? mul_res : 32'h0;
  assign rsp_ovf  = mul_vld & mul_ovf;
  assign rsp_last = tag_out.vld & tag_out.last;
  assign busy     = (state == LOCKED) | in_flight;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios plus a random run checked
// against a double-precision product model and an abstract grant model.
module tb_fp_mul_arbiter;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_vld = '0, req_last = '0;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]    req_rdy, rsp_vld;
  logic [31:0]     rsp_res;
  logic            rsp_ovf, rsp_last, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          due;
    logic [N-1:0] vec;
    logic [31:0] res;
    logic        ovf;
    logic        last;
  } exp_t;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.N_REQ(N), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_last(req_last), .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_res(rsp_res),
    .rsp_ovf(rsp_ovf), .rsp_last(rsp_last), .busy(busy)
  );

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic set_pair(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    nxt(); rst = 1'b1; req_vld = '0; req_last = '0;
    nxt(); rst = 1'b0;
  endtask

  function automatic real to_real(input logic [31:0] f);
    logic [10:0] e64;
    e64 = 11'(int'(f[30:23]) - 127 + 1023);
    return $bitstoreal({f[31], e64, f[22:0], 29'h0});
  endfunction

  // Returns {ovf, result}: exact product in double, then RNE to single.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, a_z, b_z, a_i, b_i, a_n, b_n;
    logic [63:0] d;
    logic [22:0] m;
    int          e;
    s   = a[31] ^ b[31];
    a_z = a[30:23] == 8'h00;  b_z = b[30:23] == 8'h00;
    a_i = a[30:23] == 8'hFF && a[22:0] == 0;  b_i = b[30:23] == 8'hFF && b[22:0] == 0;
    a_n = a[30:23] == 8'hFF && a[22:0] != 0;  b_n = b[30:23] == 8'hFF && b[22:0] != 0;
    if (a_n || b_n || (a_i && b_z) || (b_i && a_z)) return {1'b1, 32'h7FC00000};
    if (a_i || b_i) return {1'b1, s, 31'h7F800000};
    if (a_z || b_z) return {1'b0, s, 31'h0};
    d = $realtobits(to_real(a) * to_real(b));
    e = int'(d[62:52]) - 1023 + 127;
    m = d[51:29];
    if (d[28] && ((|d[27:0]) || m[0])) begin
      if (m == 23'h7FFFFF) begin m = 23'h0; e++; end
      else m = m + 1'b1;
    end
    if (e >= 255) return {1'b1, s, 31'h7F800000};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, 8'(e), m};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 11))
      0: r = 32'h00000000;
      1: r = 32'h80000000;
      2: r = 32'h7F800000;
      3: r = 32'hFF800000;
      4: r = 32'h7FC00001;
      5: r = 32'h00012345;
      6: r = 32'h3F800000;
      7, 8, 9, 10: r[30:23] = 8'($urandom_range(100, 154));
      default: ;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    req_vld = 4'hF; req_last = 4'hF;
    smp();
    checks++; if (req_rdy !== 4'h0) begin errors++; $display("FAIL reset_rdy: got %b, expected 0000", req_rdy); end
    checks++; if (rsp_vld !== 4'h0) begin errors++; $display("FAIL reset_rsp_vld: got %b, expected 0000", rsp_vld); end
    checks++; if (rsp_res !== 32'h0) begin errors++; $display("FAIL reset_rsp_res: got %h, expected 0", rsp_res); end
    checks++; if ({rsp_ovf, rsp_last, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b, expected 000", {rsp_ovf, rsp_last, busy}); end
    nxt(); rst = 1'b0; req_vld = '0; req_last = '0;
  endtask

  task automatic test_single();
    nxt(); req_vld = 4'b0100; req_last = 4'b0100; set_pair(2, 32'h3F800000, 32'h40000000);
    smp();
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy: got %b, expected 0100", req_rdy); end
    nxt(); req_vld = '0; req_last = '0;
    smp();
    checks++; if (rsp_vld !== 4'b0100) begin errors++; $display("FAIL single_rsp_vld: got %b, expected 0100", rsp_vld); end
    checks++; if (rsp_res !== 32'h40000000) begin errors++; $display("FAIL single_res: got %h, expected 40000000", rsp_res); end
    checks++; if ({rsp_ovf, rsp_last} !== 2'b01) begin errors++; $display("FAIL single_ovf_last: got %b, expected 01", {rsp_ovf, rsp_last}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, expected 1", busy); end
    nxt(); smp();
    checks++; if (rsp_vld !== 4'h0 || rsp_res !== 32'h0) begin errors++; $display("FAIL single_idle_rsp: got vld %b res %h, expected 0000 0", rsp_vld, rsp_res); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_contention();
    logic [31:0] a_s [N];
    logic [31:0] b_s [N];
    logic [32:0] r;
    do_reset();
    nxt(); req_vld = 4'hF; req_last = 4'hF;
    for (int i = 0; i < N; i++) begin
      a_s[i] = rand_fp(); b_s[i] = rand_fp(); set_pair(i, a_s[i], b_s[i]);
    end
    for (int k = 0; k <= N; k++) begin
      smp();
      if (k > 0) begin
        r = ref_mul(a_s[k-1], b_s[k-1]);
        checks++; if (rsp_vld !== N'(1) << (k-1)) begin errors++; $display("FAIL contend_rsp_vld[%0d]: got %b, expected %b", k-1, rsp_vld, N'(1) << (k-1)); end
        checks++; if ({rsp_ovf, rsp_res} !== r) begin errors++; $display("FAIL contend_res[%0d]: got %h, expected %h", k-1, {rsp_ovf, rsp_res}, r); end
      end
      if (k < N) begin
        checks++; if (req_rdy !== N'(1) << k) begin errors++; $display("FAIL contend_grant[%0d]: got %b, expected %b", k, req_rdy, N'(1) << k); end
      end else begin
        checks++; if (req_rdy !== 4'h0) begin errors++; $display("FAIL contend_no_grant: got %b, expected 0000", req_rdy); end
      end
      nxt();
      if (k < N) req_vld[k] = 1'b0;
    end
    req_vld = 4'hF;
    smp();
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL contend_wrap: got %b, expected 0001", req_rdy); end
    nxt(); req_vld = '0; req_last = '0;
    smp();
    checks++; if (rsp_vld !== 4'b0001) begin errors++; $display("FAIL contend_wrap_rsp: got %b, expected 0001", rsp_vld); end
  endtask

  task automatic test_burst_lock();
    logic [3:0] t_vld [8];
    logic [3:0] t_last [8];
    logic [3:0] t_rdy [8];
    logic [3:0] t_rsp [8];
    logic       t_rl [8];
    t_vld  = '{4'b0010, 4'b1011, 4'b1001, 4'b1011, 4'b1011, 4'b1001, 4'b0001, 4'b0000};
    t_last = '{4'b0000, 4'b1001, 4'b1001, 4'b1001, 4'b1011, 4'b1001, 4'b0001, 4'b0000};
    t_rdy  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001, 4'b0000};
    t_rsp  = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
    t_rl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      nxt(); req_vld = t_vld[c]; req_last = t_last[c];
      for (int i = 0; i < N; i++) set_pair(i, rand_fp(), rand_fp());
      smp();
      checks++; if (req_rdy !== t_rdy[c]) begin errors++; $display("FAIL burst_rdy[c%0d]: got %b, expected %b", c, req_rdy, t_rdy[c]); end
      checks++; if (rsp_vld !== t_rsp[c]) begin errors++; $display("FAIL burst_rsp_vld[c%0d]: got %b, expected %b", c, rsp_vld, t_rsp[c]); end
      if (t_rsp[c] != 4'h0) begin
        checks++; if (rsp_last !== t_rl[c]) begin errors++; $display("FAIL burst_rsp_last[c%0d]: got %b, expected %b", c, rsp_last, t_rl[c]); end
      end
    end
  endtask

  task automatic test_special();
    nxt(); req_vld = 4'b0001; req_last = 4'b0001; set_pair(0, 32'h7F800000, 32'h00000000);
    smp();
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL special_rdy0: got %b, expected 0001", req_rdy); end
    nxt(); set_pair(0, 32'h7F000000, 32'h7F000000);
    smp();
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL special_rdy1: got %b, expected 0001", req_rdy); end
    checks++; if ({rsp_ovf, rsp_res} !== {1'b1, 32'h7FC00000}) begin errors++; $display("FAIL special_inf_x_zero: got ovf %b res %h, expected 1 7fc00000", rsp_ovf, rsp_res); end
    nxt(); set_pair(0, 32'hBF800000, 32'h40000000);
    smp();
    checks++; if ({rsp_ovf, rsp_res} !== {1'b1, 32'h7F800000}) begin errors++; $display("FAIL special_overflow: got ovf %b res %h, expected 1 7f800000", rsp_ovf, rsp_res); end
    nxt(); req_vld = '0; req_last = '0;
    smp();
    checks++; if ({rsp_ovf, rsp_res} !== {1'b0, 32'hC0000000}) begin errors++; $display("FAIL special_negative: got ovf %b res %h, expected 0 c0000000", rsp_ovf, rsp_res); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    nxt(); req_vld = 4'b0010; req_last = 4'b0000; set_pair(1, 32'h3F800000, 32'h3F800000);
    smp();
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL midrst_accept: got %b, expected 0010", req_rdy); end
    nxt(); rst = 1'b1; req_vld = 4'b0011;
    smp();
    checks++; if (rsp_vld !== 4'h0 || req_rdy !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_during: got vld %b rdy %b busy %b, expected 0000 0000 0", rsp_vld, req_rdy, busy); end
    nxt(); rst = 1'b0; req_vld = '0;
    for (int c = 0; c < 3; c++) begin
      smp();
      checks++; if (rsp_vld !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_after[%0d]: got vld %b busy %b, expected 0000 0", c, rsp_vld, busy); end
      nxt();
    end
    req_vld = 4'b0011; req_last = 4'b0011;
    smp();
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL midrst_idle_grant: got %b, expected 0001", req_rdy); end
    nxt(); req_vld = '0; req_last = '0;
    smp();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_s [16];
    logic [31:0] b_s [16];
    logic [32:0] r;
    for (int k = 0; k <= 16; k++) begin
      nxt();
      if (k < 16) begin
        a_s[k] = rand_fp(); b_s[k] = rand_fp(); set_pair(0, a_s[k], b_s[k]);
        req_vld = 4'b0001; req_last = (k == 15) ? 4'b0001 : 4'b0000;
      end else begin
        req_vld = '0; req_last = '0;
      end
      smp();
      if (k < 16) begin
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL b2b_rdy[%0d]: got %b, expected 0001", k, req_rdy); end
      end
      if (k > 0) begin
        r = ref_mul(a_s[k-1], b_s[k-1]);
        checks++; if (rsp_vld !== 4'b0001) begin errors++; $display("FAIL b2b_rsp_vld[%0d]: got %b, expected 0001", k-1, rsp_vld); end
        checks++; if ({rsp_ovf, rsp_res} !== r) begin errors++; $display("FAIL b2b_res[%0d]: got %h, expected %h", k-1, {rsp_ovf, rsp_res}, r); end
        checks++; if (rsp_last !== (k == 16)) begin errors++; $display("FAIL b2b_last[%0d]: got %b, expected %b", k-1, rsp_last, k == 16); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d]: got %b, expected 1", k-1, busy); end
      end
    end
    nxt(); smp();
    checks++; if (rsp_vld !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got vld %b busy %b, expected 0000 0", rsp_vld, busy); end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    logic [31:0] a_cur [N];
    logic [31:0] b_cur [N];
    logic [32:0] r;
    logic [N-1:0] exp_rdy;
    int owner, rr, g;
    do_reset();
    owner = -1; rr = 0;
    for (int c = 0; c < 400 + LAT + 1; c++) begin
      nxt();
      if (c < 400) begin
        for (int i = 0; i < N; i++) begin
          req_vld[i]  = ($urandom_range(0, 2) != 0);
          req_last[i] = ($urandom_range(0, 3) == 0);
          a_cur[i] = rand_fp(); b_cur[i] = rand_fp(); set_pair(i, a_cur[i], b_cur[i]);
        end
      end else begin
        req_vld = '0; req_last = '0;
      end
      smp();
      checks++; if (busy !== ((owner >= 0) || (q.size() > 0))) begin errors++; $display("FAIL rand_busy[c%0d]: got %b, expected %b", c, busy, (owner >= 0) || (q.size() > 0)); end
      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        checks++; if ({rsp_vld, rsp_ovf, rsp_last, rsp_res} !== {e.vec, e.ovf, e.last, e.res}) begin errors++; $display("FAIL rand_rsp[c%0d]: got vld %b ovf %b last %b res %h, expected %b %b %b %h", c, rsp_vld, rsp_ovf, rsp_last, rsp_res, e.vec, e.ovf, e.last, e.res); end
      end else begin
        checks++; if (rsp_vld !== '0 || rsp_res !== 32'h0) begin errors++; $display("FAIL rand_quiet[c%0d]: got vld %b res %h, expected 0000 0", c, rsp_vld, rsp_res); end
      end
      g = owner;
      if (g < 0) begin
        for (int k = 0; k < N; k++) if (g < 0 && req_vld[(rr + k) % N]) g = (rr + k) % N;
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      checks++; if (req_rdy !== exp_rdy) begin errors++; $display("FAIL rand_grant[c%0d]: got %b, expected %b", c, req_rdy, exp_rdy); end
      if (g >= 0 && req_vld[g]) begin
        r = ref_mul(a_cur[g], b_cur[g]);
        e.due = c + LAT; e.vec = N'(1) << g; e.res = r[31:0]; e.ovf = r[32]; e.last = req_last[g];
        q.push_back(e);
        if (req_last[g]) begin owner = -1; rr = (g + 1) % N; end
        else owner = g;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst_lock();
    test_special();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one FP32 multiplier (2..8).
REQ-002 Parameter MUL_LAT, default 1: multiplier latency in cycles, from input-valid to result-valid.
REQ-003 clk  input  1  the only clock; all logic is on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_vld  input  N_REQ  per-requester operand valid.
REQ-006 req_a  input  32*N_REQ  IEEE-754 single operand A; requester i uses bits [32i+31:32i].
REQ-007 req_b  input  32*N_REQ  IEEE-754 single operand B, same packing as req_a.
REQ-008 req_last  input  N_REQ  marks the final operand pair of requester i's burst.
REQ-009 req_rdy  output  N_REQ  one-hot-or-zero; the pair is accepted when req_vld[i] and req_rdy[i] are both high.
REQ-010 rsp_vld  output  N_REQ  one-hot-or-zero; a product for requester i is present.
REQ-011 rsp_res  output  32  product value; valid only while rsp_vld is nonzero.
REQ-012 rsp_ovf  output  1  multiplier overflow/NaN/Inf flag for the product on rsp_res.
REQ-013 rsp_last  output  1  the req_last value that travelled with this product.
REQ-014 busy  output  1  high while state is LOCKED or any product is in flight.

Function
REQ-015 FSM states: IDLE (no owner) and LOCKED (owner fixed until its burst ends).
REQ-016 In IDLE, grant goes to the first requester with req_vld high, searching round-robin from pointer rr_ptr; req_rdy for that requester is asserted in the same cycle (combinational).
REQ-017 When a pair is accepted without req_last: set owner = grantee and move to LOCKED.
REQ-018 When a pair is accepted with req_last, or in LOCKED the owner's pair with req_last is accepted: go to IDLE and set rr_ptr = (owner+1) mod N_REQ.
REQ-019 In LOCKED, only req_rdy[owner] may be high, and it is high every cycle; other requesters' req_vld is ignored, and owner gaps (req_vld low) do not release the lock.
REQ-020 At most one pair is issued per cycle; throughput is 1 product/cycle in steady state.
REQ-021 Each accepted pair drives the multiplier with i_vld=1 that cycle; i_vld=0 in all other cycles.
REQ-022 Each issue pushes a tag {requester index, req_last} into a MUL_LAT-deep shift pipeline aligned with the multiplier; no FIFO.
REQ-023 rsp_vld[tag.index] asserts exactly MUL_LAT cycles after acceptance, together with the multiplier result on rsp_res, overflow on rsp_ovf, and tag.last on rsp_last; requesters always accept responses (no backpressure).
REQ-024 rsp_res is 0 when rsp_vld is 0.
REQ-025 Products are returned in issue order; an owner's burst products are contiguous with no other requester interleaved.
REQ-026 A single-pair burst (req_last on the first pair) never enters LOCKED.
REQ-027 If req_vld is all zero in IDLE: no grant, and rr_ptr holds.

Reset
REQ-028 On rst: state=IDLE, rr_ptr=0, tag pipeline cleared, req_rdy=0 only if rst is high, rsp_vld=0, rsp_res=0, rsp_ovf=0, rsp_last=0, busy=0.
REQ-029 Reset mid-burst or mid-flight discards all in-flight products; no rsp_vld asserts for them after rst deasserts.

Structure
REQ-030 N_REQ default, MUL_LAT default, the FSM state encoding and the tag field widths go in shared package fpmm_pkg.
REQ-031 Exactly one sub-module: multiplier_32bit, instantiated once; its clk and rst are tied to the arbiter's clk and rst.
REQ-032 The round-robin pick is a purely combinational function of req_vld and rr_ptr, inside this module.

Verification
REQ-033 Single request: req 2 sends 3F800000 x 40000000 with last -> rsp_vld=4'b0100 one cycle later, rsp_res=40000000, rsp_ovf=0, rsp_last=1.
REQ-034 Contention: all four req_vld high with last, rr_ptr=0 -> grants in order 0,1,2,3 on consecutive cycles; then rr_ptr=0 again.
REQ-035 Burst lock: req 1 sends a 4-pair burst while req 0 and req 3 are valid, with a one-cycle gap on req 1 -> only req 1 is granted until its last; the next grant goes to req 3 (rr_ptr=2 search), then req 0.
REQ-036 Special values: 7F800000 x 00000000 -> 7FC00000 with rsp_ovf=1; 7F000000 x 7F000000 -> 7F800000 with rsp_ovf=1.
REQ-037 Reset mid-flight: assert rst in the cycle after an accept -> no rsp_vld afterwards, and state=IDLE.
REQ-038 Back-to-back: 16 pairs from req 0 with last on the 16th -> 16 consecutive rsp_vld cycles in order and busy is high throughout.
